spi_peripheral: RTL and testbench

//   SPI responder (target) for the SPI controller in the same design.

---
 rtl/spi_peripheral_if.sv | 25 ++
 rtl/spi_peripheral.sv | 181 ++++++++++++++++++
 tb/tb_spi_peripheral.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_peripheral_if.sv
// SPI pin group plus core-side tx/rx handshake for the SPI responder.
interface spi_peripheral_if #(parameter int DATA_W = 8);
  logic              SCK;
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              underrun;
  logic              frame_err;

  modport slave (
    input  SCK, CS, MOSI, tx_data, tx_valid,
    output MISO, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );

  modport master (
    output SCK, CS, MOSI, tx_data, tx_valid,
    input  MISO, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled SCK/CS/MOSI, one-entry tx holding register,
// rx word output with a valid pulse, underrun and framing-error pulses.
module spi_peripheral #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  spi_peripheral_if.slave bus
);
  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, cs_prev_q;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_pend_q, start_pend_d;
  logic              rx_pend_q, rx_pend_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic do_start;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign cs_rise  =  cs_s  & ~cs_prev_q;
  assign cs_fall  = ~cs_s  &  cs_prev_q;

  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    cnt_d        = cnt_q;
    start_pend_d = start_pend_q;
    rx_pend_d    = 1'b0;
    miso_d       = miso_q;
    oe_d         = oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_pend_q;
    underrun_d   = 1'b0;
    frame_err_d  = 1'b0;
    do_start     = 1'b0;

    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        oe_d         = 1'b0;
        miso_d       = 1'b0;
        cnt_d        = '0;
        start_pend_d = 1'b0;
        if (cs_fall) begin
          state_d  = SHIFT;
          oe_d     = 1'b1;
          do_start = 1'b1;
        end
      end
      SHIFT: begin
        // CS rise outranks any SCK edge seen in the same cycle
        if (cs_rise) begin
          state_d      = IDLE;
          oe_d         = 1'b0;
          miso_d       = 1'b0;
          cnt_d        = '0;
          start_pend_d = 1'b0;
          frame_err_d  = (cnt_q != '0);
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (cnt_q == CW'(DATA_W-1)) begin
            cnt_d        = '0;
            rx_data_d    = {rx_shift_q[DATA_W-2:0], mosi_s};
            rx_pend_d    = 1'b1;
            start_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (start_pend_q) begin
            start_pend_d = 1'b0;
            do_start     = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // a full register cannot accept a load, so copy and refill never collide
    if (do_start) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
        miso_d      = hold_q[DATA_W-1];
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
        miso_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      cnt_q        <= '0;
      start_pend_q <= 1'b0;
      rx_pend_q    <= 1'b0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_prev_q   <= sck_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      rx_pend_q    <= rx_pend_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.miso_oe   = oe_q;
  assign bus.tx_ready  = ~hold_full_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: the bench acts as a mode-0 SPI controller.
module tb_spi_peripheral;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_peripheral_if #(.DATA_W(8)) bus ();
  spi_peripheral #(.DATA_W(8), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_fe  = 0;
  logic [7:0] rx_hist[$];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_rxv++;
      rx_hist.push_back(bus.rx_data);
    end
    if (bus.underrun)  n_und++;
    if (bus.frame_err) n_fe++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, input int h, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      bus.MOSI = d[7-i];
      tick(h);
      m = {m[6:0], bus.MISO};
      bus.SCK = 1'b1;
      tick(h);
      bus.SCK = 1'b0;
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    int rxv0, und0, fe0;
    bus.SCK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    #12;
    check("rst_miso",     32'(bus.MISO),      32'd0);
    check("rst_oe",       32'(bus.miso_oe),   32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready),  32'd1);
    check("rst_rx_data",  32'(bus.rx_data),   32'd0);
    check("rst_flags",    32'({bus.rx_valid, bus.underrun, bus.frame_err}), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // 1: single frame, tx 0xA5, MOSI 0x3C
    load_tx(8'hA5);
    check("t1_tx_ready_full", 32'(bus.tx_ready), 32'd0);
    rxv0 = n_rxv; fe0 = n_fe;
    bus.CS = 1'b0; tick(6);
    check("t1_oe", 32'(bus.miso_oe), 32'd1);
    spi_bits(8'h3C, 8, 6, m);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t1_miso",  32'(m),            32'hA5);
    check("t1_rx",    32'(bus.rx_data),  32'h3C);
    check("t1_rxv",   32'(n_rxv - rxv0), 32'd1);
    check("t1_fe",    32'(n_fe - fe0),   32'd0);
    check("t1_oe_off", 32'(bus.miso_oe), 32'd0);

    // 2: two back-to-back words with CS held low
    load_tx(8'h11);
    rxv0 = n_rxv; rx_hist.delete();
    bus.CS = 1'b0; tick(6);
    check("t2_tx_ready_after_copy", 32'(bus.tx_ready), 32'd1);
    load_tx(8'h22);
    spi_bits(8'hF0, 8, 6, m);
    check("t2_miso0", 32'(m), 32'h11);
    spi_bits(8'h0F, 8, 6, m);
    check("t2_miso1", 32'(m), 32'h22);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t2_rxv", 32'(n_rxv - rxv0), 32'd2);
    if (rx_hist.size() == 2) begin
      check("t2_rx0", 32'(rx_hist[0]), 32'hF0);
      check("t2_rx1", 32'(rx_hist[1]), 32'h0F);
    end
    check("t2_tx_ready", 32'(bus.tx_ready), 32'd1);

    // 3: frame with nothing loaded
    und0 = n_und;
    bus.CS = 1'b0; tick(6);
    check("t3_underrun", 32'(n_und - und0), 32'd1);
    spi_bits(8'h5A, 8, 6, m);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t3_miso", 32'(m),           32'h00);
    check("t3_rx",   32'(bus.rx_data), 32'h5A);

    // 4: CS raised after 5 bits, then a full frame
    rxv0 = n_rxv; fe0 = n_fe;
    bus.CS = 1'b0; tick(6);
    spi_bits(8'hFF, 5, 6, m);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t4_fe",  32'(n_fe - fe0),   32'd1);
    check("t4_rxv", 32'(n_rxv - rxv0), 32'd0);
    check("t4_rx_held", 32'(bus.rx_data), 32'h5A);
    bus.CS = 1'b0; tick(6);
    spi_bits(8'hC3, 8, 6, m);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t4_rx_next", 32'(bus.rx_data), 32'hC3);
    check("t4_fe_next", 32'(n_fe - fe0),  32'd1);

    // 5: reset in mid-frame
    load_tx(8'h99);
    bus.CS = 1'b0; tick(6);
    spi_bits(8'hAA, 3, 6, m);
    rst_n = 1'b0; #1;
    check("t5_miso",     32'(bus.MISO),     32'd0);
    check("t5_oe",       32'(bus.miso_oe),  32'd0);
    check("t5_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("t5_rx_data",  32'(bus.rx_data),  32'd0);
    check("t5_flags",    32'({bus.rx_valid, bus.underrun, bus.frame_err}), 32'd0);
    bus.CS = 1'b1;
    tick(3);
    rxv0 = n_rxv; fe0 = n_fe; und0 = n_und;
    rst_n = 1'b1; tick(10);
    check("t5_no_pulses", 32'((n_rxv - rxv0) + (n_fe - fe0) + (n_und - und0)), 32'd0);
    load_tx(8'h7E);
    bus.CS = 1'b0; tick(6);
    spi_bits(8'h81, 8, 6, m);
    tick(6); bus.CS = 1'b1; tick(8);
    check("t5_miso_after", 32'(m),           32'h7E);
    check("t5_rx",         32'(bus.rx_data), 32'h81);
    check("t5_fe",         32'(n_fe - fe0),  32'd0);

    // 6: minimum half-period, alternating 0xFF/0x00 words
    rxv0 = n_rxv; rx_hist.delete();
    bus.CS = 1'b0; tick(4);
    spi_bits(8'hFF, 8, 4, m);
    spi_bits(8'h00, 8, 4, m);
    spi_bits(8'hFF, 8, 4, m);
    spi_bits(8'h00, 8, 4, m);
    tick(4); bus.CS = 1'b1; tick(8);
    check("t6_rxv", 32'(n_rxv - rxv0), 32'd4);
    if (rx_hist.size() == 4) begin
      check("t6_rx0", 32'(rx_hist[0]), 32'hFF);
      check("t6_rx1", 32'(rx_hist[1]), 32'h00);
      check("t6_rx2", 32'(rx_hist[2]), 32'hFF);
      check("t6_rx3", 32'(rx_hist[3]), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
